// File: rtl/vgac_param_if.sv
// Frame-buffer and VGA-pin bundle for vgac_param.
// rdn low marks row_addr/col_addr as a live read; the frame buffer must present d_in before the following vga_clk edge.
interface vgac_param_if #(
    parameter int COLOR_W = 4,
    parameter int ROW_W   = 9,
    parameter int COL_W   = 10
);
    logic [3*COLOR_W-1:0] d_in;
    logic [1:0]           mode;
    logic [ROW_W-1:0]     row_addr;
    logic [COL_W-1:0]     col_addr;
    logic                 rdn;
    logic [COLOR_W-1:0]   r;
    logic [COLOR_W-1:0]   g;
    logic [COLOR_W-1:0]   b;
    logic                 hs;
    logic                 vs;
    logic                 de;
    logic                 frame_start;
    logic                 line_start;

    modport master (
        input  d_in, mode,
        output row_addr, col_addr, rdn, r, g, b, hs, vs, de, frame_start, line_start
    );

    modport slave (
        output d_in, mode,
        input  row_addr, col_addr, rdn, r, g, b, hs, vs, de, frame_start, line_start
    );
endinterface

// File: rtl/vgac_param.sv
// Parametrised VGA timing controller: frame-buffer addressing with power-of-two
// scaling, built-in test patterns, and a two-stage output pipeline keeping sync/de/rgb aligned.
module vgac_param #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int COLOR_W     = 4,
    parameter int SCALE_SHIFT = 0,
    parameter int ROW_W       = 9,
    parameter int COL_W       = 10
) (
    input logic          vga_clk,
    input logic          clrn,
    vgac_param_if.master bus
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BC_W    = $clog2(BAR_W + 1);
    localparam int PIX_W   = 3 * COLOR_W;

    localparam logic [H_W-1:0]  H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]  H_SYNC_END = H_W'(H_SYNC);
    localparam logic [H_W-1:0]  H_START    = H_W'(H_SYNC + H_BP);
    localparam logic [H_W-1:0]  H_END      = H_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [V_W-1:0]  V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]  V_SYNC_END = V_W'(V_SYNC);
    localparam logic [V_W-1:0]  V_START    = V_W'(V_SYNC + V_BP);
    localparam logic [V_W-1:0]  V_END      = V_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [BC_W-1:0] BAR_LAST   = BC_W'(BAR_W - 1);
    localparam logic            HS_ON      = (HS_POL != 0);
    localparam logic            VS_ON      = (VS_POL != 0);

    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;
    logic             h_act, v_act, active;
    logic [H_W-1:0]   x;
    logic [V_W-1:0]   y;
    logic             line_first, frame_first;
    logic [1:0]       mode_q;
    logic [BC_W-1:0]  bar_px, cur_px;
    logic [2:0]       bar_idx, cur_idx;
    logic [PIX_W-1:0] tp, tp_q, px;
    logic             fb_sel_q, hs_q, vs_q, fs_q, ls_q;

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + V_W'(1);
        end else begin
            h <= h + H_W'(1);
        end
    end

    assign h_act       = (h >= H_START) && (h < H_END);
    assign v_act       = (v >= V_START) && (v < V_END);
    assign active      = h_act && v_act;
    assign x           = h - H_START;
    assign y           = v - V_START;
    assign line_first  = active && (x == '0);
    assign frame_first = line_first && (y == '0);

    // Bar position restarts at x == 0 so every active line begins with bar 0.
    assign cur_px  = (x == '0) ? '0 : bar_px;
    assign cur_idx = (x == '0) ? 3'd0 : bar_idx;

    // Bar order white..black maps to R = ~idx[1], G = ~idx[2], B = ~idx[0].
    always_comb begin
        tp = '0;
        case (mode_q)
            2'b01:   tp = {{COLOR_W{~cur_idx[1]}}, {COLOR_W{~cur_idx[2]}}, {COLOR_W{~cur_idx[0]}}};
            2'b10:   tp = {PIX_W{x[5] ^ y[5]}};
            default: tp = '0;
        endcase
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            mode_q       <= 2'b11;
            bar_px       <= '0;
            bar_idx      <= '0;
            bus.row_addr <= '0;
            bus.col_addr <= '0;
            bus.rdn      <= 1'b1;
            tp_q         <= '0;
            fb_sel_q     <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            fs_q         <= 1'b0;
            ls_q         <= 1'b0;
        end else begin
            if (h == '0 && v == '0) mode_q <= bus.mode;
            if (h_act) begin
                if (cur_px == BAR_LAST) begin
                    bar_px  <= '0;
                    bar_idx <= cur_idx + 3'd1;
                end else begin
                    bar_px  <= cur_px + BC_W'(1);
                    bar_idx <= cur_idx;
                end
            end
            if (active) begin
                bus.row_addr <= ROW_W'(y >> SCALE_SHIFT);
                bus.col_addr <= COL_W'(x >> SCALE_SHIFT);
            end
            bus.rdn  <= ~active;
            tp_q     <= tp;
            fb_sel_q <= (mode_q == 2'b00);
            hs_q     <= (h < H_SYNC_END);
            vs_q     <= (v < V_SYNC_END);
            fs_q     <= frame_first;
            ls_q     <= line_first;
        end
    end

    assign px = bus.rdn ? '0 : (fb_sel_q ? bus.d_in : tp_q);

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            bus.r           <= '0;
            bus.g           <= '0;
            bus.b           <= '0;
            bus.de          <= 1'b0;
            bus.hs          <= ~HS_ON;
            bus.vs          <= ~VS_ON;
            bus.frame_start <= 1'b0;
            bus.line_start  <= 1'b0;
        end else begin
            {bus.r, bus.g, bus.b} <= px;
            bus.de          <= ~bus.rdn;
            bus.hs          <= hs_q ? HS_ON : ~HS_ON;
            bus.vs          <= vs_q ? VS_ON : ~VS_ON;
            bus.frame_start <= fs_q;
            bus.line_start  <= ls_q;
        end
    end
endmodule

// File: tb/tb_vgac_param.sv
// Bench for vgac_param: two instances (unscaled active-low sync, and 2x scaled active-high sync)
// on a reduced timing set, checked every cycle against a pixel-position reference model.
module tb_vgac_param;
    localparam int HS  = 6;
    localparam int HBP = 5;
    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int VA  = 40;
    localparam int VFP = 2;
    localparam int HT  = HS + HBP + HA + HFP;
    localparam int VT  = VS + VBP + VA + VFP;
    localparam int FT  = HT * VT;
    localparam int H0  = HS + HBP;
    localparam int V0  = VS + VBP;

    // clock / reset
    logic       vga_clk = 1'b0;
    logic       clrn    = 1'b1;
    logic [1:0] mode    = 2'b00;
    always #5 vga_clk = ~vga_clk;

    vgac_param_if #(.COLOR_W(4), .ROW_W(6), .COL_W(7)) bus0 ();
    vgac_param_if #(.COLOR_W(4), .ROW_W(6), .COL_W(7)) bus1 ();
    assign bus0.mode = mode;
    assign bus1.mode = mode;

    vgac_param #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
        .HS_POL(0), .VS_POL(0), .COLOR_W(4), .SCALE_SHIFT(0), .ROW_W(6), .COL_W(7)
    ) u_dut0 (
        .vga_clk(vga_clk),
        .clrn(clrn),
        .bus(bus0)
    );

    vgac_param #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
        .HS_POL(1), .VS_POL(1), .COLOR_W(4), .SCALE_SHIFT(1), .ROW_W(6), .COL_W(7)
    ) u_dut1 (
        .vga_clk(vga_clk),
        .clrn(clrn),
        .bus(bus1)
    );

    int          checks = 0;
    int          errors = 0;
    int          edges  = 0;
    logic [1:0]  frame_mode [16];
    int          last_row [2];
    int          last_col [2];
    int          hs0_run, hs1_run, vs0_run, de0_run;
    logic [16:0] exp_q [$];
    logic [11:0] bar_colours [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                     12'hF0F, 12'hF00, 12'h00F, 12'h000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: observed %0h, expected %0h at edge %0d", tag, got, exp, edges);
        end
    endtask

    // reference model: position pos counts pixel clocks from h = v = 0
    function automatic bit pos_xy(input int pos, output int x, output int y);
        int h, v;
        h = pos % HT;
        v = (pos / HT) % VT;
        x = h - H0;
        y = v - V0;
        return (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
    endfunction

    // {rgb, hs, vs, de, frame_start, line_start} visible after edge k
    function automatic logic [16:0] model_out(input int k, input int s, input bit hp, input bit vp);
        int p, h, v, x, y;
        bit act;
        logic [11:0] rgb;
        if (k < 2) return {12'h000, ~hp, ~vp, 3'b000};
        p   = k - 2;
        h   = p % HT;
        v   = (p / HT) % VT;
        act = pos_xy(p, x, y);
        rgb = 12'h000;
        if (act) begin
            case (frame_mode[p / FT])
                2'b00:   rgb = {4'(y >> s), 4'(x >> s), 4'hA};
                2'b01:   rgb = bar_colours[x / (HA / 8)];
                2'b10:   rgb = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 12'hFFF : 12'h000;
                default: rgb = 12'h000;
            endcase
        end
        return {rgb, (h < HS) ? hp : ~hp, (v < VS) ? vp : ~vp, act,
                act && x == 0 && y == 0, act && x == 0};
    endfunction

    task automatic scoreboard();
        logic [16:0] exp_v;
        int x, y;
        bit act;
        exp_q.push_back(model_out(edges, 0, 1'b0, 1'b0));
        exp_q.push_back(model_out(edges, 1, 1'b1, 1'b1));
        exp_v = exp_q.pop_front();
        check("dut0_pixel", 32'({bus0.r, bus0.g, bus0.b, bus0.hs, bus0.vs, bus0.de,
                                  bus0.frame_start, bus0.line_start}), 32'(exp_v));
        exp_v = exp_q.pop_front();
        check("dut1_pixel", 32'({bus1.r, bus1.g, bus1.b, bus1.hs, bus1.vs, bus1.de,
                                  bus1.frame_start, bus1.line_start}), 32'(exp_v));
        act = pos_xy(edges - 1, x, y);
        for (int s = 0; s < 2; s++) begin
            if (act) begin
                last_row[s] = (y >> s) & 63;
                last_col[s] = (x >> s) & 127;
            end
        end
        check("dut0_rdn", 32'(bus0.rdn), 32'(!act));
        check("dut0_row", 32'(bus0.row_addr), 32'(last_row[0]));
        check("dut0_col", 32'(bus0.col_addr), 32'(last_col[0]));
        check("dut1_rdn", 32'(bus1.rdn), 32'(!act));
        check("dut1_row", 32'(bus1.row_addr), 32'(last_row[1]));
        check("dut1_col", 32'(bus1.col_addr), 32'(last_col[1]));
    endtask

    // pulse widths measured directly on the pins
    task automatic track_widths();
        if (!bus0.hs) hs0_run++;
        else begin
            if (hs0_run > 0) check("hs0_width", 32'(hs0_run), 32'(HS));
            hs0_run = 0;
        end
        if (bus1.hs) hs1_run++;
        else begin
            if (hs1_run > 0) check("hs1_width", 32'(hs1_run), 32'(HS));
            hs1_run = 0;
        end
        if (!bus0.vs) vs0_run++;
        else begin
            if (vs0_run > 0) check("vs0_width", 32'(vs0_run), 32'(VS * HT));
            vs0_run = 0;
        end
        if (bus0.de) de0_run++;
        else begin
            if (de0_run > 0) check("de0_width", 32'(de0_run), 32'(HA));
            de0_run = 0;
        end
    endtask

    // driver tasks
    task automatic drive_mode(input bit scripted);
        if (scripted && edges == 20 * HT + 5) mode = 2'b10;
        else if (scripted && edges == FT + 10 * HT) mode = 2'b01;
        else if ((!scripted || edges > 2 * FT) && $urandom_range(0, 599) == 0)
            mode = 2'($urandom_range(0, 3));
    endtask

    task automatic drive_ram();
        bus0.d_in = {bus0.row_addr[3:0], bus0.col_addr[3:0], 4'hA};
        bus1.d_in = {bus1.row_addr[3:0], bus1.col_addr[3:0], 4'hA};
    endtask

    task automatic check_reset_state();
        check("rst_rgb0", 32'({bus0.r, bus0.g, bus0.b}), 32'h0);
        check("rst_hs0", 32'(bus0.hs), 32'h1);
        check("rst_vs0", 32'(bus0.vs), 32'h1);
        check("rst_de0", 32'(bus0.de), 32'h0);
        check("rst_strobes0", 32'({bus0.frame_start, bus0.line_start}), 32'h0);
        check("rst_rdn0", 32'(bus0.rdn), 32'h1);
        check("rst_addr0", 32'({bus0.row_addr, bus0.col_addr}), 32'h0);
        check("rst_rgb1", 32'({bus1.r, bus1.g, bus1.b}), 32'h0);
        check("rst_hs1", 32'(bus1.hs), 32'h0);
        check("rst_vs1", 32'(bus1.vs), 32'h0);
        check("rst_de1", 32'(bus1.de), 32'h0);
        check("rst_addr1", 32'({bus1.row_addr, bus1.col_addr}), 32'h0);
    endtask

    // called at a negedge with clrn low
    task automatic do_release(input logic [1:0] m);
        mode  = m;
        edges = 0;
        for (int i = 0; i < 16; i++) frame_mode[i] = 2'b11;
        frame_mode[0] = m;
        last_row = '{0, 0};
        last_col = '{0, 0};
        hs0_run = 0;
        hs1_run = 0;
        vs0_run = 0;
        de0_run = 0;
        drive_ram();
        clrn = 1'b1;
    endtask

    task automatic run_segment(input int n_edges, input bit scripted);
        for (int i = 0; i < n_edges; i++) begin
            @(posedge vga_clk);
            edges++;
            @(negedge vga_clk);
            scoreboard();
            track_widths();
            drive_mode(scripted);
            if (edges % FT == 0) frame_mode[edges / FT] = mode;
            drive_ram();
        end
    endtask

    initial begin
        bus0.d_in = '0;
        bus1.d_in = '0;
        #1 clrn = 1'b0;
        repeat (3) @(negedge vga_clk);
        check_reset_state();
        do_release(2'b00);
        run_segment(4 * FT + 20 * HT + 30, 1'b1);
        // asynchronous reset in the middle of an active line
        clrn = 1'b0;
        #1;
        check_reset_state();
        repeat (3) @(negedge vga_clk);
        do_release(2'b00);
        run_segment(3 * FT + 50, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vgac_param.md
Name: vgac_param

Overview:
- Parametrised successor to the fixed 640x480@60 VGA controller.
- Generates horizontal/vertical timing from parameters, issues frame-buffer read addresses with optional power-of-two pixel scaling, and registers RGB output aligned with hs/vs/de.
- Adds selectable sync polarity, a built-in test-pattern generator, and frame/line strobes.
- Sits between the frame-buffer RAM (synchronous, 1-cycle read latency) and the VGA pins.

Parameters:
- H_SYNC, 96, hsync pulse width in pixel clocks
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line (multiple of 8)
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- COLOR_W, 4, bits per colour channel
- SCALE_SHIFT, 0, address downscale: each fb pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels
- ROW_W, 9, row_addr width
- COL_W, 10, col_addr width

Ports:
- vga_clk  in  1  pixel clock
- clrn  in  1  asynchronous active-low reset
- d_in  in  3*COLOR_W  pixel data from frame buffer, packed {R,G,B} with R in the MSBs
- mode  in  2  00 frame buffer, 01 colour bars, 10 checkerboard, 11 forced black
- row_addr  out  ROW_W  frame-buffer row = y >> SCALE_SHIFT
- col_addr  out  COL_W  frame-buffer column = x >> SCALE_SHIFT
- rdn  out  1  active-low read strobe, low while the address is in the active area
- r, g, b  out  COLOR_W each  registered colour outputs
- hs, vs  out  1 each  sync outputs, polarity per HS_POL/VS_POL
- de  out  1  display enable, aligned with r/g/b
- frame_start  out  1  one-cycle pulse with the first active pixel of a frame on r/g/b
- line_start  out  1  one-cycle pulse with the first active pixel of each active line

Behaviour:
- One clock (vga_clk). Reset is asynchronous and active-low (clrn); every register, including both counters, is cleared asynchronously.
- Reset values:
  - counters 0, row_addr/col_addr 0, rdn 1
  - r/g/b 0, de 0, frame_start/line_start 0
  - hs = ~HS_POL, vs = ~VS_POL
  - latched mode = 11 (black)
- Counters:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
  - h wraps H_TOTAL-1 -> 0.
  - v increments only when h = H_TOTAL-1, wrapping V_TOTAL-1 -> 0.
- Line order is sync, back porch, active, front porch (same for frames).
  - Active when H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACTIVE and the vertical equivalent holds.
  - x = h-(H_SYNC+H_BP), y = v-(V_SYNC+V_BP).
- Sync is asserted while h < H_SYNC (resp. v < V_SYNC).
- Stage 1 (edge after counter value c):
  - row_addr/col_addr load from c; in blanking they hold their last value.
  - rdn = ~active(c); test-pattern colour is computed; hs/vs/frame/line flags are delayed.
- Stage 2 (next edge):
  - r/g/b = rdn ? 0 : selected source.
  - de = ~rdn; hs, vs, frame_start, line_start are output.
  - Total pipeline is 2 cycles for every output, so hs/vs/de/rgb stay mutually aligned.
- d_in is sampled in stage 2, i.e. exactly one cycle after the matching address appears.
- mode is latched only when h = 0 and v = 0. A mid-frame change takes effect at the next frame.
- Colour bars:
  - Eight bars of H_ACTIVE/8 pixels each, selected by a bar counter that resets at the start of each active line.
  - Order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
- Checkerboard: white when x[5]^y[5] = 1, else black. Uses unscaled x/y.
- Width rules:
  - Addresses are truncated to ROW_W/COL_W after the shift.
  - All counters are wide enough for H_TOTAL-1 and V_TOTAL-1.
- Reset mid-frame: outputs return to reset values immediately. After release, timing restarts at h = v = 0 and mode is latched at that first edge.

Test Plan:
- Defaults, reset released -> H_TOTAL = 800, V_TOTAL = 525. hs low for exactly 96 cycles per line, vs low for exactly 1600 cycles, vs period 420000 cycles.
- mode = 00, RAM model returns {row[3:0], col[3:0], 4'hA} -> first de-high cycle carries col 0, row 0. de high 640 cycles per line and 480 lines per frame; frame_start pulses once per frame, coincident with that pixel.
- mode = 01 -> r/g/b = FFF for pixels 0-79, FF0 for 80-159, ..., 000 for 560-639. Output is 000 whenever de = 0.
- mode changed 00 -> 10 at line 200 -> output unchanged until the next frame, which shows the checkerboard (x = 32, y = 0 gives FFF).
- SCALE_SHIFT = 1 -> col_addr sequence 0,0,1,1,...,319,319; row_addr constant across screen-line pairs.
- HS_POL = 1, VS_POL = 1 -> sync pulses invert, same widths. clrn pulsed low mid-line -> all outputs at reset values within the same cycle; timing restarts from h = v = 0.
